// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle on a shared 64-bit shift register.
// Optional MULDIV_EARLY_OUT_EN: x/0, DIV overflow and multiply-by-zero finish one cycle after start.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [4:0]       r_cnt;
    logic [2:0]       r_f3;
    logic             r_neg;
    logic             r_dz;
    logic [31:0]      r_op;
    logic [63:0]      r_acc;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_result;

    logic             w_is_div, w_sgn1, w_sgn2, w_neg1, w_neg2, w_neg_res, w_dz;
    logic [31:0]      w_mag1, w_mag2;
    logic [32:0]      w_sum;
    logic             w_ge;
    logic [31:0]      w_sub;
    logic [63:0]      w_step, w_prod_fix;
    logic [31:0]      w_quo_fix, w_rem_fix, w_fix_res;
    logic             w_early;
    logic [31:0]      w_early_res;

    assign w_is_div  = funct3[2];
    assign w_sgn1    = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
    assign w_sgn2    = w_sgn1 && (funct3 != 3'd2);
    assign w_neg1    = w_sgn1 && in1[31];
    assign w_neg2    = w_sgn2 && in2[31];
    assign w_mag1    = w_neg1 ? -in1 : in1;
    assign w_mag2    = w_neg2 ? -in2 : in2;
    // Remainder takes the dividend's sign; everything else is the XOR of operand signs.
    assign w_neg_res = (w_is_div && funct3[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
    assign w_dz      = w_is_div && (in2 == '0);

`ifdef MULDIV_EARLY_OUT_EN
    logic w_ovf;
    assign w_ovf   = w_is_div && !funct3[0] && (in1 == 32'h8000_0000) && (in2 == '1);
    assign w_early = w_dz || w_ovf || (!w_is_div && ((in1 == '0) || (in2 == '0)));
    always_comb begin
        w_early_res = '0;
        if (w_dz)
            w_early_res = funct3[1] ? in1 : 32'hFFFF_FFFF;
        else if (w_ovf && !funct3[1])
            w_early_res = 32'h8000_0000;
    end
`else
    assign w_early     = 1'b0;
    assign w_early_res = '0;
`endif

    // Multiply: {hi,lo} with multiplier in lo; divide: {remainder, dividend/quotient}.
    assign w_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_op} : 33'd0);
    assign w_ge  = {1'b0, r_acc[63:31]} >= {2'b00, r_op};
    assign w_sub = r_acc[62:31] - r_op;

    always_comb begin
        w_step = {w_sum, r_acc[31:1]};
        if (r_f3[2])
            w_step = w_ge ? {w_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
    end

    assign w_prod_fix = r_neg ? -r_acc : r_acc;
    assign w_quo_fix  = r_dz ? 32'hFFFF_FFFF : (r_neg ? -r_acc[31:0] : r_acc[31:0]);
    assign w_rem_fix  = r_neg ? -r_acc[63:32] : r_acc[63:32];

    always_comb begin
        w_fix_res = w_rem_fix;
        case (r_f3)
            3'd0:             w_fix_res = w_prod_fix[31:0];
            3'd1, 3'd2, 3'd3: w_fix_res = w_prod_fix[63:32];
            3'd4, 3'd5:       w_fix_res = w_quo_fix;
            default:          w_fix_res = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_op     <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_f3  <= funct3;
                        r_neg <= w_neg_res;
                        r_dz  <= w_dz;
                        r_cnt <= '0;
                        if (w_early) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_early_res;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_op    <= w_is_div ? w_mag2 : w_mag1;
                            r_acc   <= {32'd0, (w_is_div ? w_mag1 : w_mag2)};
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit (results, latency, flush, ignored start, async reset).
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int overlap = 0;
    logic [31:0] last_res = '0;

    localparam int FULL = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SP = 1;
`else
    localparam int SP = 34;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [0:20] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, FULL},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL},
        '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, FULL},
        '{3'd5, 32'd100,        32'd7,         32'd14,        FULL},
        '{3'd7, 32'd100,        32'd7,         32'd2,         FULL},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, FULL},
        '{3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, FULL},
        '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL},
        '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         FULL},
        '{3'd3, 32'h1234_5678,  32'h10,        32'd1,         FULL},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SP},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         SP},
        '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, SP},
        '{3'd6, 32'd5,          32'd0,         32'd5,         SP},
        '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, SP},
        '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, SP},
        '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, SP},
        '{3'd7, 32'd5,          32'd0,         32'd5,         SP},
        '{3'd0, 32'd0,          32'd5,         32'd0,         SP},
        '{3'd1, 32'hFFFF_FFFF,  32'd0,         32'd0,         SP}
    };

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // Clock / cycle counter / busy-done exclusivity monitor.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy && done) overlap <= overlap + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one start pulse, then scramble operands so only start-cycle values matter.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        in1    = a;
        in2    = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        t0     = cyc;
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        in1    = $urandom;
        in2    = $urandom;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = done ? (cyc - t0 + 1) : 0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        launch(f, a, b);
        if (exp_lat > 1)
            check({tag, ".busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".notbusy"}, 32'(busy), 32'd0);
        check(tag, result, exp);
        last_res = exp;
    endtask

    initial begin
        int lat;
        int seen;
        #2 rst = 1'b0;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.state", 32'(dbg_state), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table ops run back-to-back: each launch happens in the previous DONE cycle.
        for (int i = 0; i < 21; i++)
            do_op($sformatf("v%0d_f%0d", i, vecs[i].f), vecs[i].f, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].lat);

        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_state", 32'(dbg_state), 32'd0);

        // A start while busy must be ignored.
        launch(3'd0, 32'd3, 32'd5);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        funct3 = 3'd0;
        in1    = 32'd2;
        in2    = 32'd2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign.busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("ign.lat", 32'(lat), 32'd34);
        check("ign.result", result, 32'd15);
        last_res = 32'd15;

        // Flush mid-divide, with a simultaneous start that must lose.
        launch(3'd5, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush  = 1'b1;
        start  = 1'b1;
        funct3 = 3'd0;
        in1    = 32'd9;
        in2    = 32'd9;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.state", 32'(dbg_state), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("flush.no_done", 32'(seen), 32'd0);
        check("flush.result", result, last_res);

        // Asynchronous reset in the middle of a multiply.
        launch(3'd0, 32'd5, 32'd6);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b0;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        check("arst.result", result, 32'd0);
        check("arst.state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("arst.no_done", 32'(seen), 32'd0);
        do_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, FULL);

        check("busy_done_overlap", 32'(overlap), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
